fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register and a RUN/HALT FSM; jumps insert one bubble.
// Optional fetch counter is built only when FETCH_PERF_CNT_EN is defined; otherwise fetch_cnt is tied to zero.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jmp_en,
  input  logic [7:0]  jmp_addr,
  input  logic [23:0] imem_rdata,
  output logic [7:0]  imem_addr,
  output logic [23:0] ins,
  output logic        ins_valid,
  output logic [7:0]  ins_pc,
  output logic        halted,
  output logic [15:0] fetch_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [4:0] HALT_OP = 5'b11111;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [23:0] ins_q, ins_d;
  logic [7:0]  ins_pc_q, ins_pc_d;
  logic        ins_valid_q, ins_valid_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    ins_pc_d    = ins_pc_q;
    ins_valid_d = ins_valid_q;
    if (jmp_en) begin
      // A redirect beats stall and also leaves HALT.
      pc_d        = jmp_addr;
      ins_d       = '0;
      ins_valid_d = 1'b0;
      state_d     = RUN;
    end else if (!stall) begin
      case (state_q)
        RUN: begin
          ins_d       = imem_rdata;
          ins_pc_d    = pc_q;
          ins_valid_d = 1'b1;
          pc_d        = pc_q + 8'd1;
          if (imem_rdata[23:19] == HALT_OP) state_d = HALT;
        end
        HALT: begin
          ins_d       = '0;
          ins_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= '0;
      ins_q       <= '0;
      ins_pc_q    <= '0;
      ins_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      ins_pc_q    <= ins_pc_d;
      ins_valid_q <= ins_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (!jmp_en && !stall && state_q == RUN && fetch_cnt_q != 16'hFFFF)
      fetch_cnt_d = fetch_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) fetch_cnt_q <= '0;
    else       fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`else
  assign fetch_cnt = 16'h0000;
`endif

  assign imem_addr = pc_q;
  assign ins       = ins_q;
  assign ins_pc    = ins_pc_q;
  assign ins_valid = ins_valid_q;
  assign halted    = (state_q == HALT);

endmodule
